// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver: synchronizes SCK/LRCK/SD, deserializes {left,right} frames, valid/ready output.
// Optional I2S_RX_ERR_CNT_EN adds err_count/err_clr.
module i2s_rx #(
    parameter int CH_BITS    = 16,
    parameter int DATA_DELAY = 0
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 sck,
    input  logic                 lrck,
    input  logic                 sd,
    output logic [2*CH_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 locked
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [15:0]          err_count,
    input  logic                 err_clr
`endif
);

    localparam int CW = $clog2(2*CH_BITS) + 1;
    localparam int SW = $clog2(DATA_DELAY + 1) + 1;
    localparam logic [CW-1:0] CNT_CH    = CW'(CH_BITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(2*CH_BITS);
    localparam logic [SW-1:0] SKIP_INIT = SW'(DATA_DELAY);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t               state;
    logic [2:0]           sck_q;
    logic [2:0]           lrck_q;
    logic [1:0]           sd_q;
    logic [CW-1:0]        bit_cnt;
    logic [SW-1:0]        skip_cnt;
    logic [CH_BITS-1:0]   left_sr;
    logic [CH_BITS-1:0]   right_sr;

    logic                 sck_rise;
    logic                 lrck_rise;
    logic                 lrck_fall;
    logic                 sd_bit;
    logic                 ch_end;
    logic                 chan_edge;
    logic                 in_right;
    logic                 active;
    logic                 bad_end;
    logic                 publish;
    logic                 ovr_now;
    logic [CW-1:0]        cnt_base;
    logic [SW-1:0]        skip_base;

    // Pins are asynchronous; sd shares the sck/lrck pipeline depth so bits stay aligned to strobes.
    always_ff @(posedge clkin) begin
        sck_q  <= {sck_q[1:0], sck};
        lrck_q <= {lrck_q[1:0], lrck};
        sd_q   <= {sd_q[0], sd};
    end

    always_comb begin
        sck_rise  = sck_q[1] & ~sck_q[2];
        lrck_rise = lrck_q[1] & ~lrck_q[2];
        lrck_fall = ~lrck_q[1] & lrck_q[2];
        sd_bit    = sd_q[1];
        ch_end    = ((state == LEFT) && lrck_rise) || ((state == RIGHT) && lrck_fall);
        chan_edge = ch_end || ((state == SYNC) && lrck_fall);
        in_right  = ((state == LEFT) && lrck_rise) || ((state == RIGHT) && !lrck_fall);
        active    = (state != SYNC) || lrck_fall;
        bad_end   = ch_end && (bit_cnt != CNT_CH);
        publish   = (state == RIGHT) && lrck_fall;
        ovr_now   = publish && sample_valid && !sample_ready;
        // A coincident SCK rise is counted against the channel the LRCK edge starts.
        cnt_base  = chan_edge ? '0 : bit_cnt;
        skip_base = chan_edge ? SKIP_INIT : skip_cnt;
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    always_comb begin
        err_inc = {1'b0, bad_end} + {1'b0, ovr_now};
        err_sum = {1'b0, err_count} + {15'b0, err_inc};
    end
`endif

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state        <= SYNC;
            bit_cnt      <= '0;
            skip_cnt     <= '0;
            left_sr      <= '0;
            right_sr     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
            err_count    <= '0;
`endif
        end else begin
            case (state)
                SYNC:    if (lrck_fall) state <= LEFT;
                LEFT:    if (lrck_rise) state <= RIGHT;
                RIGHT:   if (lrck_fall) state <= LEFT;
                default: state <= SYNC;
            endcase

            if (chan_edge) begin
                bit_cnt  <= '0;
                skip_cnt <= SKIP_INIT;
            end

            if (sck_rise && active) begin
                if (skip_base != '0) begin
                    skip_cnt <= skip_base - 1'b1;
                end else begin
                    if (cnt_base < CNT_CH) begin
                        if (in_right)
                            right_sr <= {right_sr[CH_BITS-2:0], sd_bit};
                        else
                            left_sr  <= {left_sr[CH_BITS-2:0], sd_bit};
                    end
                    if (cnt_base < CNT_MAX)
                        bit_cnt <= cnt_base + 1'b1;
                    else
                        bit_cnt <= cnt_base;
                end
            end

            if (bad_end)
                frame_err <= 1'b1;

            if (publish) begin
                sample       <= {left_sr, right_sr};
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                if (ovr_now)
                    overrun <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

`ifdef I2S_RX_ERR_CNT_EN
            if (err_clr) begin
                err_count <= '0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end else if (err_sum[16]) begin
                err_count <= 16'hFFFF;
            end else begin
                err_count <= err_sum[15:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx: serializer stimulus, frame scoreboard, direct flag checks.
module tb_i2s_rx;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck   = 1'b0;
    logic        lrck  = 1'b1;
    logic        sd    = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] s0, s1;
    logic        v0, v1, o0, o1, fe0, fe1, lk0, lk1;
`ifdef I2S_RX_ERR_CNT_EN
    logic [15:0] ec0, ec1;
    logic        err_clr = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [15:0] lmodel = '0;
    logic [15:0] rmodel = '0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          nl;
        int          nr;
        bit          at_rise;
        logic        err_exp;
    } vec_t;
    vec_t vt[5];

    always #5 clkin = ~clkin;

    i2s_rx #(.CH_BITS(16), .DATA_DELAY(0)) dut0 (
        .clkin(clkin), .rst_n(rst_n), .sck(sck), .lrck(lrck), .sd(sd),
        .sample(s0), .sample_valid(v0), .sample_ready(ready),
        .overrun(o0), .frame_err(fe0), .locked(lk0)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_count(ec0), .err_clr(err_clr)
`endif
    );

    i2s_rx #(.CH_BITS(16), .DATA_DELAY(1)) dut1 (
        .clkin(clkin), .rst_n(rst_n), .sck(sck), .lrck(lrck), .sd(sd),
        .sample(s1), .sample_valid(v1), .sample_ready(ready),
        .overrun(o1), .frame_err(fe1), .locked(lk1)
`ifdef I2S_RX_ERR_CNT_EN
        , .err_count(ec1), .err_clr(err_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake on dut0 must match the oldest pushed frame.
    always @(negedge clkin) begin
        if (rst_n && v0 && ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame got %h expected none", s0);
            end else begin
                chk("frame", s0, q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    function automatic logic slot_bit(input logic [15:0] w, input int i, input int delay);
        int k;
        k = i - delay;
        if (k < 0 || k > 15) return 1'b0;
        return w[15-k];
    endfunction

    // One LRCK half: n SCK periods of 8 clkin; data changes on SCK fall.
    task automatic drive_half(input logic lr, input logic [15:0] w, input int n,
                              input int delay, input bit at_rise);
        for (int i = 0; i < n; i++) begin
            sck = 1'b0;
            sd  = slot_bit(w, i, delay);
            if (i == 0 && !at_rise) lrck = lr;
            tick(4);
            sck = 1'b1;
            if (i == 0 && at_rise) lrck = lr;
            tick(4);
            if (i < 16) begin
                if (lr) rmodel = {rmodel[14:0], sd};
                else    lmodel = {lmodel[14:0], sd};
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr,
                              input int delay, input bit at_rise, input bit push);
        drive_half(1'b0, l, nl, delay, at_rise);
        drive_half(1'b1, r, nr, delay, at_rise);
        if (push) q.push_back({lmodel, rmodel});
    endtask

    task automatic tail();
        drive_half(1'b0, 16'h0000, 2, 0, 1'b0);
        tick(10);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            tick(1);
            k++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sample"}, s0, 32'h0);
        chk({tag, "_valid"}, v0, 1'b0);
        chk({tag, "_overrun"}, o0, 1'b0);
        chk({tag, "_frame_err"}, fe0, 1'b0);
        chk({tag, "_locked"}, lk0, 1'b0);
`ifdef I2S_RX_ERR_CNT_EN
        chk({tag, "_err_count"}, ec0, 32'h0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sck   = 1'b0;
        lrck  = 1'b1;
        sd    = 1'b0;
        tick(3);
        rst_n  = 1'b1;
        lmodel = '0;
        rmodel = '0;
        q.delete();
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'hA5A5, 16'h3C3C, 16, 16, 1'b0, 1'b0};
        vt[1] = '{16'hA5A5, 16'h3C3C, 16, 16, 1'b0, 1'b0};
        vt[2] = '{16'h1234, 16'hFEDC, 16, 16, 1'b1, 1'b0};
        vt[3] = '{16'hFFFF, 16'h1234, 15, 16, 1'b0, 1'b1};
        vt[4] = '{16'h0001, 16'h8000, 16, 16, 1'b0, 1'b1};

        // Reset state, then streamed frames incl. coincident edges and a truncated left channel.
        do_reset();
        check_zero("reset");
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_frame(vt[i].l, vt[i].r, vt[i].nl, vt[i].nr, 0, vt[i].at_rise, 1'b1);
            chk($sformatf("frame_err_v%0d", i), fe0, vt[i].err_exp);
        end
        tail();
        wait_empty("table_drain");
        chk("t1_overrun", o0, 1'b0);
        chk("t1_locked", lk0, 1'b1);

        // Consumer stalled across two frames: second overwrites first.
        do_reset();
        ready = 1'b0;
        send_frame(16'h1111, 16'h2222, 16, 16, 0, 1'b0, 1'b0);
        send_frame(16'h3333, 16'h4444, 16, 16, 0, 1'b0, 1'b1);
        tail();
        chk("ovr_sample", s0, 32'h33334444);
        chk("ovr_valid", v0, 1'b1);
        chk("ovr_flag", o0, 1'b1);
        @(posedge clkin);
        #1 ready = 1'b1;
        tick(1);
        chk("ovr_valid_drop", v0, 1'b0);
        wait_empty("ovr_drain");

        // Standard I2S (one-SCK delay) stream into both DATA_DELAY builds.
        do_reset();
        ready = 1'b0;
        send_frame(16'h8001, 16'h7FFE, 17, 17, 1, 1'b0, 1'b1);
        tail();
        chk("dd1_sample", s1, 32'h80017FFE);
        chk("dd1_valid", v1, 1'b1);
        chk("dd1_frame_err", fe1, 1'b0);
        chk("dd0_sample", s0, 32'h40003FFF);
        chk("dd0_frame_err", fe0, 1'b1);
        ready = 1'b1;
        wait_empty("dd_drain");

        // Reset mid-left channel discards the partial frame and forces resync.
        do_reset();
        ready = 1'b1;
        send_frame(16'h0F0F, 16'hF0F0, 16, 16, 0, 1'b0, 1'b1);
        fork
            begin
                drive_half(1'b0, 16'hBEEF, 16, 0, 1'b0);
                drive_half(1'b1, 16'hCAFE, 16, 0, 1'b0);
            end
            begin
                tick(40);
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
                check_zero("midrst");
            end
        join
        q.delete();
        send_frame(16'h5A5A, 16'h6969, 16, 16, 0, 1'b0, 1'b1);
        chk("midrst_no_early_valid", lk0, 1'b0);
        send_frame(16'hC001, 16'h0C03, 16, 16, 0, 1'b0, 1'b1);
        tail();
        wait_empty("midrst_drain");
        chk("midrst_locked", lk0, 1'b1);

`ifdef I2S_RX_ERR_CNT_EN
        // Three bad channels plus one overrun, then a clear pulse.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send_frame(16'hFFFF, 16'h0F0F, 15, 16, 0, 1'b0, 1'b1);
        drive_half(1'b0, 16'h2468, 16, 0, 1'b0);
        ready = 1'b0;
        drive_half(1'b1, 16'h1357, 16, 0, 1'b0);
        send_frame(16'hABCD, 16'hEF01, 16, 16, 0, 1'b0, 1'b1);
        tail();
        chk("ec_count", ec0, 32'd4);
        chk("ec_overrun", o0, 1'b1);
        ready = 1'b1;
        wait_empty("ec_drain");
        @(posedge clkin);
        #1 err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ec_clr_count", ec0, 32'd0);
        chk("ec_clr_overrun", o0, 1'b0);
        chk("ec_clr_frame_err", fe0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
